// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction fetch memory: FSM state
// encoding, default geometry and the NOP word.
package if_pkg;

    localparam int IF_INSTR_W = 9;
    localparam int IF_ADDR_W  = 8;

    localparam logic [IF_INSTR_W-1:0] IF_NOP_INSTR = 9'b0_0000_0000;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/imem_sp_ram.sv
// Single-port synchronous RAM with a registered read port; the read register
// can be cleared to a fixed value so the consumer never sees stale data.
module imem_sp_ram #(
    parameter int               WIDTH   = 9,
    parameter int               DEPTH   = 256,
    parameter int               AW      = $clog2(DEPTH),
    parameter logic [WIDTH-1:0] CLR_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             we,
    input  logic             re,
    input  logic             rd_clr,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Array write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    // Registered read port with synchronous clear.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem_r[addr];
        end else if (rd_clr) begin
            rdata <= CLR_VAL;
        end
    end

endmodule

// File: rtl/instr_fetch_mem.sv
// Instruction memory with a program-load port, a one-cycle-latency fetch
// handshake and end-of-program detection against the loaded program length.
module instr_fetch_mem
    import if_pkg::*;
#(
    parameter int                 INSTR_W   = IF_INSTR_W,
    parameter int                 ADDR_W    = IF_ADDR_W,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(IF_NOP_INSTR)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_start,
    input  logic               load_en,
    input  logic [ADDR_W:0]    load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               load_done,
    output logic               load_err,
    input  logic               restart,
    output logic               fetch_ready,
    input  logic               fetch_req,
    input  logic [ADDR_W-1:0]  fetch_addr,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic               done,
    output logic [ADDR_W:0]    prog_len
);

    localparam int DEPTH = 2 ** ADDR_W;

    fetch_state_e       state_r;
    fetch_state_e       state_nxt_s;
    logic [ADDR_W:0]    prog_len_r;
    logic [ADDR_W:0]    prog_len_nxt_s;
    logic [ADDR_W:0]    load_len_s;
    logic               load_in_range_s;
    logic               fetch_in_range_s;
    logic               load_err_r;
    logic               load_err_nxt_s;
    logic               instr_valid_r;
    logic               instr_valid_nxt_s;
    logic               done_r;
    logic               fetch_ready_r;
    logic               ram_we_s;
    logic               ram_re_s;
    logic               ram_clr_s;
    logic [ADDR_W-1:0]  ram_addr_s;
    logic [INSTR_W-1:0] ram_rdata_s;

    // Address range checks, all in ADDR_W+1-bit unsigned arithmetic.
    always_comb begin
        load_in_range_s  = (load_addr[ADDR_W] == 1'b0);
        load_len_s       = {1'b0, load_addr[ADDR_W-1:0]} + {{ADDR_W{1'b0}}, 1'b1};
        fetch_in_range_s = ({1'b0, fetch_addr} < prog_len_r);
    end

    // Next-state, program-length and RAM control decode.
    always_comb begin
        state_nxt_s       = state_r;
        prog_len_nxt_s    = prog_len_r;
        load_err_nxt_s    = 1'b0;
        instr_valid_nxt_s = 1'b0;
        ram_we_s          = 1'b0;
        ram_re_s          = 1'b0;
        ram_addr_s        = (state_r == LOAD) ? load_addr[ADDR_W-1:0] : fetch_addr;

        if (reset) begin
            state_nxt_s    = LOAD;
            prog_len_nxt_s = {(ADDR_W+1){1'b0}};
        end else if (load_start) begin
            // load_start outranks restart/load_done and squashes any fetch.
            state_nxt_s    = LOAD;
            prog_len_nxt_s = {(ADDR_W+1){1'b0}};
        end else begin
            case (state_r)
                LOAD: begin
                    if (load_en && load_in_range_s) begin
                        ram_we_s = 1'b1;
                        if (load_len_s > prog_len_r) begin
                            prog_len_nxt_s = load_len_s;
                        end else begin
                            prog_len_nxt_s = prog_len_r;
                        end
                    end else if (load_en) begin
                        load_err_nxt_s = 1'b1;
                    end else begin
                        ram_we_s = 1'b0;
                    end
                    if (load_done) begin
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = LOAD;
                    end
                end
                RUN: begin
                    if (fetch_req && fetch_in_range_s) begin
                        ram_re_s          = 1'b1;
                        instr_valid_nxt_s = 1'b1;
                    end else if (fetch_req) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                DONE: begin
                    if (restart) begin
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = DONE;
                    end
                end
                default: begin
                    state_nxt_s    = LOAD;
                    prog_len_nxt_s = {(ADDR_W+1){1'b0}};
                end
            endcase
        end

        ram_clr_s = ~ram_re_s;
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= LOAD;
            prog_len_r    <= {(ADDR_W+1){1'b0}};
            load_err_r    <= 1'b0;
            instr_valid_r <= 1'b0;
            done_r        <= 1'b0;
            fetch_ready_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            prog_len_r    <= prog_len_nxt_s;
            load_err_r    <= load_err_nxt_s;
            instr_valid_r <= instr_valid_nxt_s;
            done_r        <= (state_nxt_s == DONE);
            fetch_ready_r <= (state_nxt_s == RUN);
        end
    end

    imem_sp_ram #(
        .WIDTH   (INSTR_W),
        .DEPTH   (DEPTH),
        .AW      (ADDR_W),
        .CLR_VAL (NOP_INSTR)
    ) u_ram (
        .clk    (clk),
        .we     (ram_we_s),
        .re     (ram_re_s),
        .rd_clr (ram_clr_s),
        .addr   (ram_addr_s),
        .wdata  (load_data),
        .rdata  (ram_rdata_s)
    );

    assign load_err    = load_err_r;
    assign instr_valid = instr_valid_r;
    assign instr       = ram_rdata_s;
    assign done        = done_r;
    assign fetch_ready = fetch_ready_r;
    assign prog_len    = prog_len_r;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Self-checking bench for instr_fetch_mem: directed scenarios followed by
// randomized traffic, all checked against a behavioural model of the rules.
module tb_instr_fetch_mem;

    localparam int IW    = 9;
    localparam int AW    = 8;
    localparam int DEPTH = 256;
    localparam logic [IW-1:0] NOP = 9'b0_0000_0000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load_start = 1'b0;
    logic          load_en = 1'b0;
    logic [AW:0]   load_addr = '0;
    logic [IW-1:0] load_data = '0;
    logic          load_done = 1'b0;
    logic          load_err;
    logic          restart = 1'b0;
    logic          fetch_ready;
    logic          fetch_req = 1'b0;
    logic [AW-1:0] fetch_addr = '0;
    logic [IW-1:0] instr;
    logic          instr_valid;
    logic          done;
    logic [AW:0]   prog_len;

    always #5 clk = ~clk;

    instr_fetch_mem #(.INSTR_W(IW), .ADDR_W(AW), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .load_start(load_start), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data), .load_done(load_done),
        .load_err(load_err), .restart(restart), .fetch_ready(fetch_ready),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .instr(instr),
        .instr_valid(instr_valid), .done(done), .prog_len(prog_len)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: mode 0 = loading, 1 = running, 2 = program finished.
    int            m_mode = 0;
    int            m_plen = 0;
    logic [IW-1:0] m_mem [DEPTH];
    bit            m_known [DEPTH];
    bit            e_valid, e_err, e_known;
    logic [IW-1:0] e_instr;

    logic [IW-1:0] demo [8] = '{9'b100001100, 9'b000110101, 9'b011000010, 9'b110010001,
                                9'b001101110, 9'b101000011, 9'b010111000, 9'b111100101};

    task automatic model_step();
        int la, fa;
        la = int'(load_addr);
        fa = int'(fetch_addr);
        e_valid = 1'b0; e_err = 1'b0; e_known = 1'b1; e_instr = NOP;
        if (reset) begin
            m_mode = 0; m_plen = 0;
        end else if (load_start) begin
            m_mode = 0; m_plen = 0;
        end else if (m_mode == 0) begin
            if (load_en) begin
                if (la < DEPTH) begin
                    m_mem[la] = load_data;
                    m_known[la] = 1'b1;
                    if (la + 1 > m_plen) m_plen = la + 1;
                end else begin
                    e_err = 1'b1;
                end
            end
            if (load_done) m_mode = 1;
        end else if (m_mode == 1) begin
            if (fetch_req) begin
                if (fa < m_plen) begin
                    e_valid = 1'b1;
                    e_known = m_known[fa];
                    e_instr = m_mem[fa];
                end else begin
                    m_mode = 2;
                end
            end
        end else begin
            if (restart) m_mode = 1;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_eq("instr_valid", 32'(instr_valid), 32'(e_valid));
        if (e_known) check_eq("instr", 32'(instr), 32'(e_instr));
        check_eq("done", 32'(done), 32'(m_mode == 2));
        check_eq("fetch_ready", 32'(fetch_ready), 32'(m_mode == 1));
        check_eq("load_err", 32'(load_err), 32'(e_err));
        check_eq("prog_len", 32'(prog_len), 32'(m_plen));
    endtask

    task automatic idle();
        reset = 1'b0; load_start = 1'b0; load_en = 1'b0; load_done = 1'b0;
        restart = 1'b0; fetch_req = 1'b0;
    endtask

    task automatic write_word(input int a, input logic [IW-1:0] d);
        load_en = 1'b1; load_addr = (AW+1)'(a); load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic fetch(input int a);
        fetch_req = 1'b1; fetch_addr = AW'(a);
        tick();
        fetch_req = 1'b0;
    endtask

    initial begin
        int vcount;
        int hi;
        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;

        // Reset state
        reset = 1'b1; tick(); tick();
        check_eq("rst_instr", 32'(instr), 32'(NOP));
        idle();

        // Demo program load and back-to-back fetch
        load_start = 1'b1; tick(); load_start = 1'b0;
        for (int i = 0; i < 8; i++) write_word(i, demo[i]);
        load_done = 1'b1; tick(); load_done = 1'b0;
        check_eq("plen8", 32'(prog_len), 32'd8);
        vcount = 0;
        for (int i = 0; i < 8; i++) begin
            fetch_req = 1'b1; fetch_addr = AW'(i); tick();
            if (instr_valid) vcount++;
        end
        check_eq("valid_run", 32'(vcount), 32'd8);

        // End of program, ignored fetch, restart
        fetch(8);
        check_eq("done_at8", 32'(done), 32'd1);
        fetch(0);
        check_eq("ign_in_done", 32'(instr_valid), 32'd0);
        restart = 1'b1; tick(); restart = 1'b0;
        fetch(0);
        check_eq("restart_instr", 32'(instr), 32'(9'b100001100));
        check_eq("restart_done", 32'(done), 32'd0);

        // Out-of-range write, then write coincident with load_done
        load_start = 1'b1; tick(); load_start = 1'b0;
        write_word(256, 9'h1AB);
        check_eq("err_pulse", 32'(load_err), 32'd1);
        tick();
        check_eq("err_clear", 32'(load_err), 32'd0);
        load_en = 1'b1; load_addr = 9'd3; load_data = 9'h0F3; load_done = 1'b1;
        tick(); idle();
        check_eq("plen4", 32'(prog_len), 32'd4);
        fetch(3);
        check_eq("addr3", 32'(instr), 32'(9'h0F3));

        // Sparse program at address 200
        load_start = 1'b1; tick(); load_start = 1'b0;
        write_word(200, 9'h155);
        load_done = 1'b1; tick(); load_done = 1'b0;
        check_eq("plen201", 32'(prog_len), 32'd201);
        fetch(200);
        fetch(201);
        check_eq("done_201", 32'(done), 32'd1);

        // Reset mid-fetch-stream, then empty program
        restart = 1'b1; tick(); restart = 1'b0;
        fetch_req = 1'b1; fetch_addr = 8'd200; tick();
        reset = 1'b1; tick(); reset = 1'b0;
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
        fetch_req = 1'b0;
        load_done = 1'b1; tick(); load_done = 1'b0;
        fetch(0);
        check_eq("empty_done", 32'(done), 32'd1);

        // Full-depth program: last address fetches normally
        load_start = 1'b1; tick(); load_start = 1'b0;
        write_word(255, 9'h1C3);
        load_done = 1'b1; tick(); load_done = 1'b0;
        check_eq("plen256", 32'(prog_len), 32'd256);
        fetch(255);

        // load_start + restart with a fetch pending
        load_start = 1'b1; tick(); load_start = 1'b0;
        for (int i = 0; i < 4; i++) write_word(i, 9'(i * 37 + 5));
        load_done = 1'b1; tick(); load_done = 1'b0;
        fetch_req = 1'b1; fetch_addr = 8'd1; load_start = 1'b1; restart = 1'b1;
        tick(); idle();
        check_eq("squash_valid", 32'(instr_valid), 32'd0);
        check_eq("squash_plen", 32'(prog_len), 32'd0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            reset      = ($urandom_range(0, 199) == 0);
            load_start = ($urandom_range(0, 59) == 0);
            load_done  = ($urandom_range(0, 24) == 0);
            restart    = ($urandom_range(0, 14) == 0);
            load_en    = ($urandom_range(0, 1) == 0);
            load_addr  = ($urandom_range(0, 19) == 0) ? (AW+1)'($urandom_range(256, 511))
                                                      : (AW+1)'($urandom_range(0, 40));
            load_data  = IW'($urandom_range(0, 511));
            fetch_req  = ($urandom_range(0, 3) != 0);
            hi = m_plen + 2;
            if (hi > 255) hi = 255;
            fetch_addr = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(0, 255))
                                                     : AW'($urandom_range(0, hi));
            tick();
        end
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
